// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic light controller: phase codes, LED
// encodings and the active-low 7-segment digit table.
package traffic_pkg;

  // Phase codes as seen on the state output.
  typedef enum logic [2:0] {
    StMg    = 3'd0,
    StMy    = 3'd1,
    StAr1   = 3'd2,
    StSg    = 3'd3,
    StSy    = 3'd4,
    StAr2   = 3'd5,
    StFlash = 3'd6
  } phase_e;

  // LED bit order is {red, yellow, green}.
  localparam logic [2:0] LedOff    = 3'b000;
  localparam logic [2:0] LedGreen  = 3'b001;
  localparam logic [2:0] LedYellow = 3'b010;
  localparam logic [2:0] LedRed    = 3'b100;

  // Active-low segments, bit order gfedcba; all ones turns the digit off.
  localparam logic [6:0] SegBlank = 7'h7F;

  typedef struct packed {
    logic [2:0] main;
    logic [2:0] side;
  } led_pair_t;

  // Steady-phase lamp pattern; anything unexpected shows all red.
  function automatic led_pair_t leds_for(phase_e ph);
    led_pair_t l;
    case (ph)
      StMg:    l = '{main: LedGreen,  side: LedRed};
      StMy:    l = '{main: LedYellow, side: LedRed};
      StSg:    l = '{main: LedRed,    side: LedGreen};
      StSy:    l = '{main: LedRed,    side: LedYellow};
      default: l = '{main: LedRed,    side: LedRed};
    endcase
    return l;
  endfunction

  // Digit table; codes above 9 blank the digit.
  function automatic logic [6:0] seg7_lut(logic [3:0] digit);
    logic [6:0] s;
    case (digit)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = SegBlank;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_dec.sv
// Single-digit active-low 7-segment decoder (gfedcba); blanks for inputs > 9.
module seg7_dec
  import traffic_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);

  // Pure table lookup.
  always_comb begin
    seg_o = seg7_lut(digit_i);
  end

endmodule

// File: rtl/traffic_ctrl_p.sv
// Two-road traffic light controller with tick divider, phase countdown and
// two-digit countdown display. Optional night-flash mode: TRAFFIC_FLASH_EN.
module traffic_ctrl_p
  import traffic_pkg::*;
#(
  parameter int unsigned DIV   = 25000000,
  parameter int unsigned CNT_W = 8,
  parameter int unsigned MG_T  = 60,
  parameter int unsigned SG_T  = 20,
  parameter int unsigned Y_T   = 4,
  parameter int unsigned AR_T  = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             side_req_i,
`ifdef TRAFFIC_FLASH_EN
  input  logic             night_i,
`endif
  output logic [2:0]       main_led_o,
  output logic [2:0]       side_led_o,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] cnt_o,
  output logic [6:0]       seg_tens_o,
  output logic [6:0]       seg_ones_o,
  output logic             tick_o
);

  localparam longint unsigned MaxT = 64'd1 << CNT_W;
  localparam int unsigned DivW = (DIV > 1) ? $clog2(DIV) : 1;

  if (DIV < 2) begin : g_bad_div
    $error("traffic_ctrl_p: DIV must be at least 2");
  end
  if (MG_T < 1 || SG_T < 1 || Y_T < 1 || AR_T < 1 ||
      64'(MG_T) > MaxT || 64'(SG_T) > MaxT || 64'(Y_T) > MaxT || 64'(AR_T) > MaxT)
  begin : g_bad_dur
    $error("traffic_ctrl_p: every duration must lie in 1..2**CNT_W");
  end

  localparam logic [CNT_W-1:0] MgLoad = CNT_W'(MG_T - 1);
  localparam logic [CNT_W-1:0] SgLoad = CNT_W'(SG_T - 1);
  localparam logic [CNT_W-1:0] YLoad  = CNT_W'(Y_T - 1);
  localparam logic [CNT_W-1:0] ArLoad = CNT_W'(AR_T - 1);

  logic [DivW-1:0]  div_q, div_d;
  logic             tick;
  phase_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  led_pair_t        led_q, led_d;
`ifdef TRAFFIC_FLASH_EN
  logic             flash_q, flash_d;
`endif

  assign tick = (div_q == DivW'(DIV - 1));

  // Free-running tick divider.
  always_comb begin
    div_d = tick ? '0 : div_q + DivW'(1);
  end

  // Phase sequencing; everything holds between ticks.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
`ifdef TRAFFIC_FLASH_EN
    flash_d = flash_q;
`endif
    if (tick) begin
`ifdef TRAFFIC_FLASH_EN
      if (night_i) begin
        // Night overrides every phase; yellows start lit and toggle per tick.
        flash_d = (state_q == StFlash) ? ~flash_q : 1'b1;
        state_d = StFlash;
        cnt_d   = '0;
      end else
`endif
      begin
        case (state_q)
          StMg: begin
            if (cnt_q != '0) begin
              cnt_d = cnt_q - CNT_W'(1);
            end else if (side_req_i) begin
              state_d = StMy;
              cnt_d   = YLoad;
            end else begin
              cnt_d = MgLoad;
            end
          end
          StMy: begin
            if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
            else begin
              state_d = StAr1;
              cnt_d   = ArLoad;
            end
          end
          StAr1: begin
            if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
            else begin
              state_d = StSg;
              cnt_d   = SgLoad;
            end
          end
          StSg: begin
            // Side green ends early as soon as demand goes away.
            if (!side_req_i || cnt_q == '0) begin
              state_d = StSy;
              cnt_d   = YLoad;
            end else begin
              cnt_d = cnt_q - CNT_W'(1);
            end
          end
          StSy: begin
            if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
            else begin
              state_d = StAr2;
              cnt_d   = ArLoad;
            end
          end
          StAr2: begin
            if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
            else begin
              state_d = StMg;
              cnt_d   = MgLoad;
            end
          end
          default: begin
            // Leaving FLASH, or recovering from an unused code: safe all-red.
            state_d = StAr2;
            cnt_d   = ArLoad;
          end
        endcase
      end
    end
  end

  // Lamp pattern follows the phase being entered so the LEDs stay registered.
  always_comb begin
    led_d = leds_for(state_d);
`ifdef TRAFFIC_FLASH_EN
    if (state_d == StFlash) begin
      led_d = flash_d ? '{main: LedYellow, side: LedYellow} : '{main: LedOff, side: LedOff};
    end
`endif
  end

  // State registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q   <= '0;
      state_q <= StMg;
      cnt_q   <= MgLoad;
      led_q   <= '{main: LedGreen, side: LedRed};
`ifdef TRAFFIC_FLASH_EN
      flash_q <= 1'b0;
`endif
    end else begin
      div_q   <= div_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      led_q   <= led_d;
`ifdef TRAFFIC_FLASH_EN
      flash_q <= flash_d;
`endif
    end
  end

  int unsigned cnt_ext;
  logic [3:0]  tens_dig, ones_dig;
  logic        blank;

  // Split the countdown into decimal digits; out-of-range values go dark.
  always_comb begin
    cnt_ext  = 32'(cnt_q);
    blank    = (cnt_ext >= 32'd100);
`ifdef TRAFFIC_FLASH_EN
    blank    = blank | (state_q == StFlash);
`endif
    tens_dig = 4'(cnt_ext / 32'd10);
    ones_dig = 4'(cnt_ext % 32'd10);
    if (blank) begin
      tens_dig = 4'hF;
      ones_dig = 4'hF;
    end
  end

  seg7_dec u_seg_tens (
    .digit_i (tens_dig),
    .seg_o   (seg_tens_o)
  );

  seg7_dec u_seg_ones (
    .digit_i (ones_dig),
    .seg_o   (seg_ones_o)
  );

  assign tick_o     = tick;
  assign state_o    = state_q;
  assign cnt_o      = cnt_q;
  assign main_led_o = led_q.main;
  assign side_led_o = led_q.side;

endmodule

// File: tb/tb_traffic_ctrl_p.sv
// Bench for traffic_ctrl_p: directed tick-by-tick table, multi-cycle corner
// sequences, then randomized inputs against a phase-level reference model.
module tb_traffic_ctrl_p;

  localparam int unsigned DIV   = 4;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned MG_T  = 6;
  localparam int unsigned SG_T  = 4;
  localparam int unsigned Y_T   = 2;
  localparam int unsigned AR_T  = 1;

  logic clk = 1'b0;
  logic rst_n;
  logic side_req;
`ifdef TRAFFIC_FLASH_EN
  logic night;
`endif
  logic [2:0]       main_led, side_led, state;
  logic [CNT_W-1:0] cnt;
  logic [6:0]       seg_tens, seg_ones;
  logic             tick;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  traffic_ctrl_p #(
    .DIV   (DIV),
    .CNT_W (CNT_W),
    .MG_T  (MG_T),
    .SG_T  (SG_T),
    .Y_T   (Y_T),
    .AR_T  (AR_T)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .side_req_i (side_req),
`ifdef TRAFFIC_FLASH_EN
    .night_i    (night),
`endif
    .main_led_o (main_led),
    .side_led_o (side_led),
    .state_o    (state),
    .cnt_o      (cnt),
    .seg_tens_o (seg_tens),
    .seg_ones_o (seg_ones),
    .tick_o     (tick)
  );

  // Lit segments (active-high gfedcba) for digits 0..9.
  logic [6:0] seg_hi [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                              7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  // Phase tables indexed by phase code 0..5.
  int         dur     [6] = '{MG_T, Y_T, AR_T, SG_T, Y_T, AR_T};
  int         succ    [6] = '{1, 2, 3, 4, 5, 0};
  logic [2:0] main_of [6] = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100};
  logic [2:0] side_of [6] = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100};

  // Reference model state.
  int m_div, m_phase, m_rem;
  bit m_flash;

  typedef struct {
    logic       sreq;
    logic [2:0] st;
    logic [7:0] cnt;
    logic [2:0] ml;
    logic [2:0] sl;
  } vec_t;
  vec_t tbl [22];

  function automatic logic [31:0] mk_exp(input logic tk, input logic [2:0] st,
                                         input int c, input logic [2:0] ml,
                                         input logic [2:0] sl, input bit blank);
    logic [6:0] t, o;
    if (blank || c >= 100) begin
      t = 7'h7F;
      o = 7'h7F;
    end else begin
      t = ~seg_hi[c / 10];
      o = ~seg_hi[c % 10];
    end
    return {tk, st, 8'(c), ml, sl, t, o};
  endfunction

  function automatic logic [31:0] dut_vec();
    return {tick, state, cnt, main_led, side_led, seg_tens, seg_ones};
  endfunction

  function automatic logic [31:0] model_vec();
    logic [2:0] ml, sl;
    if (m_phase == 6) begin
      ml = m_flash ? 3'b010 : 3'b000;
      sl = ml;
    end else begin
      ml = main_of[m_phase];
      sl = side_of[m_phase];
    end
    return mk_exp(m_div == DIV - 1, 3'(m_phase), m_rem, ml, sl, m_phase == 6);
  endfunction

  task automatic model_reset();
    m_div   = 0;
    m_phase = 0;
    m_rem   = MG_T - 1;
    m_flash = 0;
  endtask

  // One clock edge of the traffic rules, applied only when a tick is due.
  task automatic model_edge(input bit sreq, input bit nt);
    bit tk;
    tk    = (m_div == DIV - 1);
    m_div = tk ? 0 : m_div + 1;
    if (!tk) return;
    if (nt) begin
      m_flash = (m_phase == 6) ? !m_flash : 1'b1;
      m_phase = 6;
      m_rem   = 0;
    end else if (m_phase == 6) begin
      m_phase = 5;
      m_rem   = AR_T - 1;
    end else if (m_phase == 3 && !sreq) begin
      m_phase = 4;
      m_rem   = Y_T - 1;
    end else if (m_rem > 0) begin
      m_rem = m_rem - 1;
    end else if (m_phase == 0 && !sreq) begin
      m_rem = MG_T - 1;
    end else begin
      m_phase = succ[m_phase];
      m_rem   = dur[m_phase] - 1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Wait for tick_o (bounded); n counts clock edges waited.
  task automatic wait_tick(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (tick !== 1'b1 && n < 4 * DIV);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Advance one tick and confirm the 4-clock spacing.
  task automatic one_tick(input string name);
    int n;
    wait_tick(n);
    check({name, "_period"}, 32'(n), 32'(DIV - 1));
    step();
  endtask

  function automatic vec_t mk(input logic s, input logic [2:0] st, input logic [7:0] c,
                              input logic [2:0] ml, input logic [2:0] sl);
    vec_t v;
    v.sreq = s; v.st = st; v.cnt = c; v.ml = ml; v.sl = sl;
    return v;
  endfunction

  initial begin
    int k;
    // MG countdown with no demand, then full cycle with demand held.
    tbl[0]  = mk(0, 0, 4, 3'b001, 3'b100);
    tbl[1]  = mk(0, 0, 3, 3'b001, 3'b100);
    tbl[2]  = mk(0, 0, 2, 3'b001, 3'b100);
    tbl[3]  = mk(0, 0, 1, 3'b001, 3'b100);
    tbl[4]  = mk(0, 0, 0, 3'b001, 3'b100);
    tbl[5]  = mk(0, 0, 5, 3'b001, 3'b100);
    tbl[6]  = mk(1, 0, 4, 3'b001, 3'b100);
    tbl[7]  = mk(1, 0, 3, 3'b001, 3'b100);
    tbl[8]  = mk(1, 0, 2, 3'b001, 3'b100);
    tbl[9]  = mk(1, 0, 1, 3'b001, 3'b100);
    tbl[10] = mk(1, 0, 0, 3'b001, 3'b100);
    tbl[11] = mk(1, 1, 1, 3'b010, 3'b100);
    tbl[12] = mk(1, 1, 0, 3'b010, 3'b100);
    tbl[13] = mk(1, 2, 0, 3'b100, 3'b100);
    tbl[14] = mk(1, 3, 3, 3'b100, 3'b001);
    tbl[15] = mk(1, 3, 2, 3'b100, 3'b001);
    tbl[16] = mk(1, 3, 1, 3'b100, 3'b001);
    tbl[17] = mk(1, 3, 0, 3'b100, 3'b001);
    tbl[18] = mk(1, 4, 1, 3'b100, 3'b010);
    tbl[19] = mk(1, 4, 0, 3'b100, 3'b010);
    tbl[20] = mk(1, 5, 0, 3'b100, 3'b100);
    tbl[21] = mk(1, 0, 5, 3'b001, 3'b100);

    rst_n    = 1'b0;
    side_req = 1'b0;
`ifdef TRAFFIC_FLASH_EN
    night    = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", dut_vec(), mk_exp(0, 0, 5, 3'b001, 3'b100, 0));
    rst_n = 1'b1;

    for (int i = 0; i < 22; i++) begin
      side_req = tbl[i].sreq;
      one_tick($sformatf("tbl%0d", i));
      check($sformatf("tbl%0d", i), dut_vec(),
            mk_exp(0, tbl[i].st, int'(tbl[i].cnt), tbl[i].ml, tbl[i].sl, 0));
    end

    // Demand drops in side green with two ticks left.
    side_req = 1'b1;
    k = 0;
    while (!(state == 3'd3 && cnt == 8'd2) && k < 20) begin
      one_tick("to_sg2");
      k++;
    end
    check("reach_sg2", {21'd0, state, cnt}, {21'd0, 3'd3, 8'd2});
    side_req = 1'b0;
    one_tick("sg_drop");
    check("sg_drop", dut_vec(), mk_exp(0, 4, 1, 3'b100, 3'b010, 0));

    // Asynchronous reset in the middle of side yellow.
    step();
    rst_n = 1'b0;
    #1;
    check("rst_async", dut_vec(), mk_exp(0, 0, 5, 3'b001, 3'b100, 0));
    repeat (2) step();
    check("rst_hold", dut_vec(), mk_exp(0, 0, 5, 3'b001, 3'b100, 0));
    rst_n = 1'b1;
    one_tick("rst_release");
    check("rst_first_tick", dut_vec(), mk_exp(0, 0, 4, 3'b001, 3'b100, 0));

`ifdef TRAFFIC_FLASH_EN
    side_req = 1'b1;
    k = 0;
    while (state != 3'd3 && k < 20) begin
      one_tick("to_sg");
      k++;
    end
    check("reach_sg", {29'd0, state}, 32'd3);
    night = 1'b1;
    one_tick("flash1");
    check("flash1", dut_vec(), mk_exp(0, 6, 0, 3'b010, 3'b010, 1));
    one_tick("flash2");
    check("flash2", dut_vec(), mk_exp(0, 6, 0, 3'b000, 3'b000, 1));
    one_tick("flash3");
    check("flash3", dut_vec(), mk_exp(0, 6, 0, 3'b010, 3'b010, 1));
    night = 1'b0;
    one_tick("flash_exit");
    check("flash_exit", dut_vec(), mk_exp(0, 5, 0, 3'b100, 3'b100, 0));
    one_tick("flash_mg");
    check("flash_mg", dut_vec(), mk_exp(0, 0, 5, 3'b001, 3'b100, 0));
`endif

    // Randomized run against the reference model.
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rand_init", dut_vec(), model_vec());
    for (int i = 0; i < 1500; i++) begin
      bit nt;
      @(posedge clk);
`ifdef TRAFFIC_FLASH_EN
      nt = night;
`else
      nt = 1'b0;
`endif
      if (rst_n) model_edge(side_req, nt);
      #1;
      check("rand", dut_vec(), model_vec());
      side_req = ($urandom_range(0, 3) != 0);
`ifdef TRAFFIC_FLASH_EN
      if ($urandom_range(0, 15) == 0) night = ~night;
`endif
      if (!rst_n) begin
        if ($urandom_range(0, 2) == 0) rst_n = 1'b1;
      end else if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rand_rst", dut_vec(), model_vec());
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
